// File: rtl/puc_control_pkg.sv
// puc_control_pkg: shared state encoding for the CPU run controller
package puc_control_pkg;
    localparam int STATE_WIDTH = 3;
    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        HALTED = 3'd1,
        STEP   = 3'd2,
        RUN    = 3'd3,
        BREAK  = 3'd4
    } run_state_t;
endpackage

// File: rtl/cpu_run_controller_if.sv
// cpu_run_controller_if: board/CPU-facing signals of the run controller
interface cpu_run_controller_if
    import puc_control_pkg::*;
#(
    parameter int PC_WIDTH    = 4,
    parameter int COUNT_WIDTH = 16
);
    logic                   switch;
    logic                   runLevel;
    logic [PC_WIDTH-1:0]    pc;
    logic                   breakEnable;
    logic [PC_WIDTH-1:0]    breakAddress;
    logic                   cpuReset;
    logic                   cpuEnable;
    logic                   halted;
    logic [COUNT_WIDTH-1:0] stepCount;
    logic [STATE_WIDTH-1:0] state;
    modport master (
        output switch, runLevel, pc, breakEnable, breakAddress,
        input  cpuReset, cpuEnable, halted, stepCount, state
    );
    modport slave (
        input  switch, runLevel, pc, breakEnable, breakAddress,
        output cpuReset, cpuEnable, halted, stepCount, state
    );
endinterface

// File: rtl/switch_debouncer.sv
// switch_debouncer: 2-flop synchronizer, stable-sample debounce and a one-cycle press pulse on 0->1
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic isReset,
    input  logic switch,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    // cnt holds how many consecutive samples have disagreed with the accepted level
    always_ff @(posedge clock) begin
        if (isReset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], switch};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                press <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: CPU reset hold, free-run/single-step gating and step counter.
// Define PUC_BREAKPOINT_EN to build the PC breakpoint and the BREAK state.
module cpu_run_controller
    import puc_control_pkg::*;
#(
    parameter int PC_WIDTH        = 4,
    parameter int RESET_CYCLES    = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COUNT_WIDTH     = 16
) (
    input logic               clock,
    input logic               isReset,
    cpu_run_controller_if.slave bus
);
    localparam int HW = $clog2(RESET_CYCLES + 1);
    run_state_t             st;
    logic [HW-1:0]          hold_cnt;
    logic [COUNT_WIDTH-1:0] step_cnt;
    logic                   press, unused_level, break_hit, cpu_en;
    logic [PC_WIDTH-1:0]    pc, brk_addr;
    assign pc       = bus.pc;
    assign brk_addr = bus.breakAddress;
    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
        .clock   (clock),
        .isReset (isReset),
        .switch  (bus.switch),
        .level   (unused_level),
        .press   (press)
    );
`ifdef PUC_BREAKPOINT_EN
    assign break_hit = bus.breakEnable && pc == brk_addr;
`else
    logic unused_break;
    assign unused_break = ^{bus.breakEnable, pc, brk_addr};
    assign break_hit    = 1'b0;
`endif
    // enable is decoded from pc directly so the CPU never executes the breakpoint instruction
    assign cpu_en = st == STEP || (st == RUN && !break_hit);
    always_ff @(posedge clock) begin
        if (isReset) begin
            st       <= HOLD;
            hold_cnt <= '0;
            step_cnt <= '0;
        end else begin
            hold_cnt <= st == HOLD ? hold_cnt + 1'b1 : '0;
            if (cpu_en && step_cnt != '1)
                step_cnt <= step_cnt + 1'b1;
            case (st)
                HOLD:    st <= hold_cnt == HW'(RESET_CYCLES - 1) ? HALTED : HOLD;
                HALTED:  st <= press ? (bus.runLevel ? RUN : STEP) : HALTED;
                STEP:    st <= HALTED;
                RUN:     st <= break_hit ? BREAK : (press || !bus.runLevel) ? HALTED : RUN;
`ifdef PUC_BREAKPOINT_EN
                BREAK:   st <= press ? STEP : BREAK;
`endif
                default: st <= HOLD;
            endcase
        end
    end
    assign bus.cpuReset  = st == HOLD;
    assign bus.cpuEnable = cpu_en;
    assign bus.halted    = st == HALTED || st == BREAK;
    assign bus.stepCount = step_cnt;
    assign bus.state     = st;
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: directed checks of reset hold, stepping, debounce, breakpoint and run stop
module tb_cpu_run_controller;
    logic clock = 1'b0;
    logic isReset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [3:0] pc_m = '0;
    int   en_cycles = 0;
    int   pulses = 0;
    logic prev_en = 1'b0;
    int   n, p0, e0;

    cpu_run_controller_if #(.PC_WIDTH(4), .COUNT_WIDTH(16)) bus ();

    cpu_run_controller #(
        .PC_WIDTH(4), .RESET_CYCLES(4), .DEBOUNCE_CYCLES(4), .COUNT_WIDTH(16)
    ) dut (
        .clock   (clock),
        .isReset (isReset),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // CPU model: pc advances once per enabled cycle and clears while held in reset
    assign bus.pc = pc_m;
    always @(posedge clock) begin
        prev_en <= bus.cpuEnable === 1'b1;
        if (bus.cpuReset === 1'b1) begin
            pc_m      <= '0;
            en_cycles <= 0;
        end else if (bus.cpuEnable === 1'b1) begin
            pc_m      <= pc_m + 1'b1;
            en_cycles <= en_cycles + 1;
        end
        if (bus.cpuEnable === 1'b1 && !prev_en)
            pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clock);
    endtask

    task automatic press();
        bus.switch = 1'b1;
        tick(10);
        bus.switch = 1'b0;
        tick(10);
    endtask

    task automatic count_hold(input string tag);
        n = 0;
        while (bus.cpuReset === 1'b1 && n < 20) begin
            n++;
            tick(1);
        end
        chk(tag, n, 4);
        chk({tag, "_state"}, 32'(bus.state), 1);
    endtask

    task automatic do_reset();
        isReset = 1'b1;
        tick(2);
        isReset = 1'b0;
        tick(6);
    endtask

    initial begin
        bus.switch = 1'b0;
        bus.runLevel = 1'b0;
        bus.breakEnable = 1'b0;
        bus.breakAddress = 4'h0;
        // 1: reset hold
        repeat (2) @(posedge clock);
        tick(1);
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_cpureset", 32'(bus.cpuReset), 1);
        chk("rst_enable", 32'(bus.cpuEnable), 0);
        chk("rst_halted", 32'(bus.halted), 0);
        chk("rst_steps", 32'(bus.stepCount), 0);
        isReset = 1'b0;
        count_hold("hold_len");
        chk("halted_flag", 32'(bus.halted), 1);
        chk("halted_steps", 32'(bus.stepCount), 0);
        // 2: three single steps
        p0 = pulses;
        repeat (3) press();
        chk("step_pulses", pulses - p0, 3);
        chk("step_cycles", en_cycles, 3);
        chk("step_pc", 32'(pc_m), 3);
        chk("step_count", 32'(bus.stepCount), 3);
        chk("step_state", 32'(bus.state), 1);
        // 3: bouncing switch never debounces
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            bus.switch = ~bus.switch;
            tick(2);
        end
        bus.switch = 1'b0;
        tick(10);
        chk("bounce_pulses", pulses - p0, 0);
        chk("bounce_state", 32'(bus.state), 1);
        chk("bounce_steps", 32'(bus.stepCount), 3);
        // 4: breakpoint at pc 5 in free-run
        do_reset();
        bus.runLevel = 1'b1;
        bus.breakEnable = 1'b1;
        bus.breakAddress = 4'h5;
        press();
`ifdef PUC_BREAKPOINT_EN
        chk("bp_state", 32'(bus.state), 4);
        chk("bp_pc", 32'(pc_m), 5);
        chk("bp_steps", 32'(bus.stepCount), 5);
        chk("bp_halted", 32'(bus.halted), 1);
        chk("bp_enable", 32'(bus.cpuEnable), 0);
        e0 = en_cycles;
        press();
        chk("bp_step_cycles", en_cycles - e0, 1);
        chk("bp_step_pc", 32'(pc_m), 6);
        chk("bp_step_state", 32'(bus.state), 1);
        chk("bp_step_count", 32'(bus.stepCount), 6);
`else
        chk("nobp_state", 32'(bus.state), 3);
        chk("nobp_past5", 32'(en_cycles > 5), 1);
        chk("nobp_enable", 32'(bus.cpuEnable), 1);
        press();
        chk("nobp_stop_state", 32'(bus.state), 1);
        chk("nobp_steps", 32'(bus.stepCount), en_cycles);
`endif
        bus.breakEnable = 1'b0;
        // 5: runLevel drop after 7 enabled cycles
        do_reset();
        bus.runLevel = 1'b1;
        bus.switch = 1'b1;
        n = 0;
        while (bus.cpuEnable !== 1'b1 && n < 30) begin
            n++;
            tick(1);
        end
        chk("run_start", 32'(bus.cpuEnable), 1);
        tick(7);
        chk("run_exit_enable", 32'(bus.cpuEnable), 1);
        bus.runLevel = 1'b0;
        tick(1);
        chk("runlvl_state", 32'(bus.state), 1);
        chk("runlvl_steps", 32'(bus.stepCount), 8);
        chk("runlvl_pc", 32'(pc_m), 8);
        bus.switch = 1'b0;
        tick(10);
        // 5b: stop a free run with a second press
        bus.runLevel = 1'b1;
        press();
        chk("press_run_state", 32'(bus.state), 3);
        press();
        chk("press_stop_state", 32'(bus.state), 1);
        chk("press_stop_steps", 32'(bus.stepCount), en_cycles);
        chk("press_stop_more", 32'(bus.stepCount > 8), 1);
        // 6: reset in the middle of a run
        do_reset();
        bus.switch = 1'b1;
        n = 0;
        while (pc_m != 4'd9 && n < 40) begin
            n++;
            tick(1);
        end
        chk("mid_pc", 32'(pc_m), 9);
        chk("mid_steps", 32'(bus.stepCount), 9);
        isReset = 1'b1;
        tick(1);
        chk("mid_rst_state", 32'(bus.state), 0);
        chk("mid_rst_cpureset", 32'(bus.cpuReset), 1);
        chk("mid_rst_enable", 32'(bus.cpuEnable), 0);
        chk("mid_rst_steps", 32'(bus.stepCount), 0);
        bus.switch = 1'b0;
        isReset = 1'b0;
        count_hold("mid_hold_len");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
